lvds_tx_lane_ctrl: RTL and testbench
====================================

# lvds_tx_lane_ctrl

Sequencer for one LVDS differential transmit lane. It brings the lane's differential output buffer out of tristate, holds a settle interval, and sends a fixed training pattern. It then serializes parallel words from a valid/ready source, LSB first, one bit per clock, and inserts an idle pattern whenever no word is offered. It sits directly in front of the differential output buffer: SER_O drives the buffer's data input, and SER_T drives its active-high tristate control.

## Interface
- WIDTH, 8: bits per word; WIDTH >= 2.
- TRAIN_WORDS, 16: number of training words sent after enable; >= 1.
- ENABLE_DELAY, 4: cycles the driver is enabled at constant 0 before training; >= 1.
- TRAIN_PATTERN, 8'h5A: training word, WIDTH bits.
- IDLE_PATTERN, 8'hBC: filler word sent in RUN when no data is accepted, WIDTH bits.

- CLK  in  1  single clock; all state changes on its rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- EN  in  1  lane enable request, level-sensitive.
- TX_DATA  in  WIDTH  word to transmit.
- TX_VALID  in  1  TX_DATA is valid.
- TX_READY  out  1  word accept strobe; a transfer happens on an edge where TX_VALID & TX_READY.
- SER_O  out  1  serial bit to the buffer data input.
- SER_T  out  1  buffer tristate; 1 = high-Z, 0 = driven.
- LINK_UP  out  1  high while in RUN.

## Operation
- Reset: asynchronous assertion forces state OFF, SER_T=1, SER_O=0, TX_READY=0, LINK_UP=0, and clears all counters and the shift register. This applies immediately, mid-word included. Release takes effect on the next CLK edge.
- All outputs are registered. TX_READY has no combinational path from TX_VALID.
- State OFF:
  - SER_T=1, SER_O=0.
  - When EN=1 is sampled, go to ENWAIT.
- State ENWAIT:
  - SER_T=0, SER_O=0 for exactly ENABLE_DELAY cycles, then go to TRAIN.
  - EN=0 at any edge returns to OFF.
- State TRAIN:
  - Shifts out TRAIN_PATTERN TRAIN_WORDS times back to back, LSB first, for TRAIN_WORDS*WIDTH cycles, then goes to RUN.
  - EN=0 at any edge returns to OFF; a partial word is abandoned.
- State RUN:
  - LINK_UP=1.
  - The first word is always IDLE_PATTERN.
  - bit_cnt runs 0..WIDTH-1 and wraps. TX_READY=1 exactly in cycles with bit_cnt==WIDTH-1 and EN=1.
  - At that word boundary, the next word is TX_DATA if TX_VALID & TX_READY, else IDLE_PATTERN. Bit 0 of the next word appears in the following cycle, so the output has no gaps.
- EN=0 in RUN:
  - TX_READY is held 0 and the current word completes.
  - At the boundary edge (bit_cnt==WIDTH-1), go to OFF.
  - SER_T=1, SER_O=0, LINK_UP=0 from the next cycle.
- EN returning to 1 during the RUN drain does not cancel shutdown. The lane goes to OFF, then restarts through ENWAIT.
- Counters: the delay counter is sized for ENABLE_DELAY, the training word counter for TRAIN_WORDS, and bit_cnt for WIDTH. No counter overflows for legal parameters.

## Timing
- Enable latency: with EN=1 sampled at edge k in OFF, SER_T=0 from cycle k+1.
- Training start: first training bit at cycle k+1+ENABLE_DELAY.
- Link up: LINK_UP=1 and the first IDLE bit at cycle k+1+ENABLE_DELAY+TRAIN_WORDS*WIDTH.
- TX_READY duty: high one cycle in every WIDTH cycles while in RUN with EN=1.
- Data latency: a word accepted at edge j shows bit 0 on SER_O in cycle j+1 and bit WIDTH-1 in cycle j+WIDTH.
- Throughput: one word per WIDTH cycles.
- TX_VALID may rise or fall at any time. Only its value at a TX_READY edge matters, and TX_DATA is ignored otherwise.
- Shutdown latency: at most WIDTH cycles from EN=0 in RUN to SER_T=1; 1 cycle from ENWAIT or TRAIN.

## Test plan
- Reset values, and startup from EN=1 (WIDTH=8, ENABLE_DELAY=3, TRAIN_WORDS=2, TRAIN_PATTERN=8'h5A, IDLE_PATTERN=8'hBC):
  - During and after reset: SER_T=1, SER_O=0, TX_READY=0, LINK_UP=0.
  - After EN=1 at edge 0: SER_T=0 from cycle 1.
  - SER_O = 0,0,0, then 0,1,0,1,1,0,1,0 twice.
  - Then LINK_UP=1 at cycle 20 with bits 0,0,1,1,1,1,0,1.
- Streaming: TX_VALID held 1 with words 8'h01, 8'h80, 8'hFF.
  - Each word is accepted on consecutive TX_READY pulses, 8 cycles apart.
  - SER_O = 1,0,0,0,0,0,0,0 / 0,0,0,0,0,0,0,1 / all 1, with no gaps.
- Gapped source: TX_VALID low across one TX_READY pulse, then high with 8'h3C.
  - One IDLE_PATTERN word is sent, then 8'h3C.
  - TX_DATA changes while TX_READY=0 have no effect.
- Graceful shutdown: EN=0 at bit_cnt=2 of a data word.
  - TX_READY stays 0 and the remaining 5 bits are sent.
  - SER_T=1, LINK_UP=0 in the cycle after bit 7.
  - Re-enable repeats the full ENWAIT and TRAIN sequence.
- Abort: EN=0 during ENWAIT, and separately mid-TRAIN, returns to OFF with SER_T=1 the next cycle.
- Asynchronous reset: RSTN=0 mid-word in RUN, asserted between clock edges, forces SER_T=1, SER_O=0, TX_READY=0, LINK_UP=0 before the next edge. On release with EN=1, the lane restarts from ENWAIT.

Source files
------------

// File: rtl/lvds_tx_lane_ctrl_if.sv
// Word source handshake for one LVDS transmit lane: the source offers TX_DATA/TX_VALID,
// the lane answers with a one-cycle TX_READY accept strobe.
interface lvds_tx_lane_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/lvds_tx_lane_ctrl.sv
// LVDS lane sequencer: tristate release, settle delay, training words, then LSB-first
// serialization of source words with idle fill. Every output is a flop.
module lvds_tx_lane_ctrl #(
  parameter int               WIDTH         = 8,
  parameter int               TRAIN_WORDS   = 16,
  parameter int               ENABLE_DELAY  = 4,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'h5A,
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = 8'hBC
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  EN,
  lvds_tx_lane_ctrl_if.slave    tx,
  output logic                  SER_O,
  output logic                  SER_T,
  output logic                  LINK_UP
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = (ENABLE_DELAY > 1) ? $clog2(ENABLE_DELAY) : 1;
  localparam int TW = (TRAIN_WORDS  > 1) ? $clog2(TRAIN_WORDS)  : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(ENABLE_DELAY - 1);
  localparam logic [TW-1:0] WORD_LAST = TW'(TRAIN_WORDS - 1);

  typedef enum logic [1:0] {OFF, ENWAIT, TRAIN, RUN} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    dly_cnt, dly_n;
  logic [TW-1:0]    word_cnt, word_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, sh_n;
  logic             drain, drain_n;
  logic             ser_o_n, ser_t_n, link_n, ready_q, ready_n;
  logic [WIDTH-1:0] nxt_word;

  assign tx.TX_READY = ready_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= OFF;
      dly_cnt  <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      drain    <= 1'b0;
      SER_O    <= 1'b0;
      SER_T    <= 1'b1;
      LINK_UP  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      dly_cnt  <= dly_n;
      word_cnt <= word_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      drain    <= drain_n;
      SER_O    <= ser_o_n;
      SER_T    <= ser_t_n;
      LINK_UP  <= link_n;
      ready_q  <= ready_n;
    end
  end

  // Outputs default to the OFF values; each state only overrides what it drives.
  always_comb begin
    state_n  = state;
    dly_n    = dly_cnt;
    word_n   = word_cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    drain_n  = drain;
    ser_o_n  = 1'b0;
    ser_t_n  = 1'b1;
    link_n   = 1'b0;
    ready_n  = 1'b0;
    nxt_word = IDLE_PATTERN;
    case (state)
      OFF: begin
        if (EN) begin
          state_n = ENWAIT;
          dly_n   = '0;
          ser_t_n = 1'b0;
        end
      end
      ENWAIT: begin
        if (!EN) begin
          state_n = OFF;
        end else begin
          ser_t_n = 1'b0;
          if (dly_cnt == DLY_LAST) begin
            state_n = TRAIN;
            bit_n   = '0;
            word_n  = '0;
            ser_o_n = TRAIN_PATTERN[0];
            sh_n    = TRAIN_PATTERN >> 1;
          end else begin
            dly_n = dly_cnt + DW'(1);
          end
        end
      end
      TRAIN: begin
        if (!EN) begin
          state_n = OFF;
        end else begin
          ser_t_n = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
            if (word_cnt == WORD_LAST) begin
              state_n = RUN;
              drain_n = 1'b0;
              link_n  = 1'b1;
              ser_o_n = IDLE_PATTERN[0];
              sh_n    = IDLE_PATTERN >> 1;
            end else begin
              word_n  = word_cnt + TW'(1);
              ser_o_n = TRAIN_PATTERN[0];
              sh_n    = TRAIN_PATTERN >> 1;
            end
          end else begin
            bit_n   = bit_cnt + BW'(1);
            ser_o_n = shreg[0];
            sh_n    = shreg >> 1;
          end
        end
      end
      RUN: begin
        // Once EN drops the current word is finished and the lane shuts down,
        // even if EN comes back before the boundary.
        drain_n = drain | ~EN;
        if (bit_cnt == BIT_LAST) begin
          if (drain_n) begin
            state_n = OFF;
          end else begin
            if (tx.TX_VALID && ready_q) nxt_word = tx.TX_DATA;
            bit_n   = '0;
            ser_t_n = 1'b0;
            link_n  = 1'b1;
            ser_o_n = nxt_word[0];
            sh_n    = nxt_word >> 1;
          end
        end else begin
          bit_n   = bit_cnt + BW'(1);
          ser_t_n = 1'b0;
          link_n  = 1'b1;
          ser_o_n = shreg[0];
          sh_n    = shreg >> 1;
          ready_n = (bit_n == BIT_LAST) && !drain_n;
        end
      end
      default: state_n = OFF;
    endcase
  end
endmodule

// File: tb/tb_lvds_tx_lane_ctrl.sv
// Directed bench for lvds_tx_lane_ctrl: startup, streaming, idle fill, graceful
// shutdown with restart, async reset mid-word, and ENWAIT/TRAIN aborts.
module tb_lvds_tx_lane_ctrl;
  logic CLK, RSTN, EN;
  logic SER_O, SER_T, LINK_UP;
  int   n_chk = 0;
  int   n_err = 0;

  lvds_tx_lane_ctrl_if #(.WIDTH(8)) tx_if ();

  lvds_tx_lane_ctrl #(
    .WIDTH(8), .TRAIN_WORDS(2), .ENABLE_DELAY(3),
    .TRAIN_PATTERN(8'h5A), .IDLE_PATTERN(8'hBC)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .tx(tx_if),
    .SER_O(SER_O), .SER_T(SER_T), .LINK_UP(LINK_UP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic so, input logic st,
                         input logic lu, input logic rdy);
    chk({tag, ".ser_o"},  32'(SER_O),          32'(so));
    chk({tag, ".ser_t"},  32'(SER_T),          32'(st));
    chk({tag, ".link"},   32'(LINK_UP),        32'(lu));
    chk({tag, ".ready"},  32'(tx_if.TX_READY), 32'(rdy));
  endtask

  // Assumes EN=1 is sampled at the next edge (edge 0); checks cycles 1..n:
  // three driven-zero cycles, then 5A LSB first repeated.
  task automatic startup_chk(input string tag, input int n);
    logic [7:0] tp;
    logic       so;
    tp = 8'h5A;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      so = (c <= 3) ? 1'b0 : tp[(c - 4) % 8];
      chk_out($sformatf("%s.c%0d", tag, c), so, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Checks one RUN word; TX_DATA/TX_VALID wiggle mid-word and must be ignored.
  // nv/nd are presented for the boundary edge that ends this word.
  task automatic expect_word(input string tag, input logic [7:0] w,
                             input logic nv, input logic [7:0] nd);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk_out($sformatf("%s.b%0d", tag, i), w[i], 1'b0, 1'b1, (i == 7));
      if (i < 7) begin
        tx_if.TX_DATA  = 8'hA5 ^ 8'(i);
        tx_if.TX_VALID = 1'(i % 2);
      end else begin
        tx_if.TX_DATA  = nd;
        tx_if.TX_VALID = nv;
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    RSTN = 1'b0;
    EN = 1'b0;
    tx_if.TX_DATA  = 8'h00;
    tx_if.TX_VALID = 1'b0;
    @(negedge CLK);
    chk_out("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    chk_out("off", 1'b0, 1'b1, 1'b0, 1'b0);
    EN = 1'b1;

    startup_chk("start", 19);
    expect_word("idle0", 8'hBC, 1'b1, 8'h01);
    expect_word("w01",   8'h01, 1'b1, 8'h80);
    expect_word("w80",   8'h80, 1'b1, 8'hFF);
    expect_word("wFF",   8'hFF, 1'b0, 8'h00);
    expect_word("gap",   8'hBC, 1'b1, 8'h3C);
    expect_word("w3C",   8'h3C, 1'b1, 8'h96);

    // 96 LSB first: 0,1,1,0,1,0,0,1. EN drops after bit 2, returns during drain.
    w = 8'h96;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk_out($sformatf("drain.b%0d", i), w[i], 1'b0, 1'b1, 1'b0);
      tx_if.TX_VALID = 1'b0;
      if (i == 2) EN = 1'b0;
      if (i == 4) EN = 1'b1;
    end
    @(negedge CLK);
    chk_out("shut", 1'b0, 1'b1, 1'b0, 1'b0);

    startup_chk("restart", 19);
    expect_word("idle1", 8'hBC, 1'b0, 8'h00);

    // Async reset between edges, mid idle word.
    w = 8'hBC;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk_out($sformatf("pre_rst.b%0d", i), w[i], 1'b0, 1'b1, (i == 7));
    end
    #2 RSTN = 1'b0;
    #1 chk_out("async_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk_out("in_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    RSTN = 1'b1;
    startup_chk("rst_restart", 2);

    EN = 1'b0;
    @(negedge CLK);
    chk_out("abort_enwait", 1'b0, 1'b1, 1'b0, 1'b0);
    EN = 1'b1;
    startup_chk("retrain", 10);
    EN = 1'b0;
    @(negedge CLK);
    chk_out("abort_train", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk_out("stay_off", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
